// File: rtl/rgmii_pkg.sv
// Shared types for the RGMII link sequencer:
// speed codes, FSM encoding, in-band tuple.
package rgmii_pkg;

  localparam logic [1:0] SPD_10   = 2'b00;
  localparam logic [1:0] SPD_100  = 2'b01;
  localparam logic [1:0] SPD_1000 = 2'b10;
  localparam logic [1:0] SPD_RSVD = 2'b11;

  typedef enum logic [2:0] {
    S_RST    = 3'd0,
    S_SETTLE = 3'd1,
    S_DOWN   = 3'd2,
    S_UP     = 3'd3
  } state_t;

  typedef struct packed {
    logic       up;
    logic [1:0] spd;
    logic       dplx;
  } ibs_t;

  function automatic logic is_gig(
    input logic [1:0] s
  );
    return s == SPD_1000;
  endfunction

endpackage

// File: rtl/rgmii_status_debounce.sv
// 2-flop synchronizer and debounce counter
// for the receiver in-band status tuple.
module rgmii_status_debounce
  import rgmii_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int CNT_W           = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       clr,
  input  logic       ibs_up,
  input  logic [1:0] ibs_spd,
  input  logic       ibs_dplx,
  output logic       stable,
  output ibs_t       tuple
);

  localparam logic [CNT_W-1:0] DB_LOAD =
    CNT_W'(DEBOUNCE_CYCLES - 1);

  ibs_t             s1;
  ibs_t             s2;
  ibs_t             prev;
  logic [CNT_W-1:0] cnt;

  // clear also flushes the synchronizer so a
  // restart always sees the tuple arrive fresh
  always_ff @(posedge clk) begin
    if (!reset_n || clr) begin
      s1   <= '0;
      s2   <= '0;
      prev <= '0;
      cnt  <= DB_LOAD;
    end else begin
      s1 <= {ibs_up, ibs_spd, ibs_dplx};
      s2 <= s1;
      if (s2 != prev) begin
        prev <= s2;
        cnt  <= DB_LOAD;
      end else if (cnt != '0) begin
        cnt <= cnt - CNT_W'(1);
      end
    end
  end

  assign stable = !clr && (s2 == prev) &&
                  (cnt == '0);
  assign tuple  = prev;

endmodule

// File: rtl/rgmii_link_ctrl.sv
// RGMII link/speed sequencer (reset, settle, debounce).
// Optional RGMII_LINK_STATS_EN adds link statistics.
module rgmii_link_ctrl
  import rgmii_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int RESET_CYCLES    = 16,
  parameter int SETTLE_CYCLES   = 64,
  parameter int CNT_W           = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ibs_up,
  input  logic [1:0]  ibs_spd,
  input  logic        ibs_dplx,
  input  logic        cfg_force,
  input  logic [1:0]  cfg_spd,
`ifdef RGMII_LINK_STATS_EN
  input  logic        stat_clr,
  output logic [15:0] stat_down_cnt,
  output logic [15:0] stat_respeed_cnt,
`endif
  output logic        rx_reset,
  output logic        speed,
  output logic        link_up,
  output logic [1:0]  link_spd,
  output logic        link_dplx,
  output logic        link_event,
  output logic [2:0]  state_o
);

  localparam logic [CNT_W-1:0] RST_LOAD =
    CNT_W'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0] SET_LOAD =
    CNT_W'(SETTLE_CYCLES - 1);

  state_t           state;
  state_t           nxt_state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] nxt_cnt;
  logic             spd_q;
  logic             nxt_spd;
  logic [1:0]       lspd_q;
  logic [1:0]       nxt_lspd;
  logic             ldplx_q;
  logic             nxt_ldplx;
  logic [3:0]       out_q;
  logic             evt_q;

  logic             db_clr;
  logic             db_stable;
  ibs_t             db_t;
  logic [1:0]       eff;
  logic             eff_gig;
  logic             eff_ok;

  assign db_clr = (state == S_RST) ||
                  (state == S_SETTLE);

  rgmii_status_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_db (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (db_clr),
    .ibs_up  (ibs_up),
    .ibs_spd (ibs_spd),
    .ibs_dplx(ibs_dplx),
    .stable  (db_stable),
    .tuple   (db_t)
  );

  assign eff     = cfg_force ? cfg_spd : db_t.spd;
  assign eff_gig = is_gig(eff);
  assign eff_ok  = db_t.up && (eff != SPD_RSVD);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state   <= S_RST;
      cnt     <= RST_LOAD;
      spd_q   <= 1'b1;
      lspd_q  <= SPD_1000;
      ldplx_q <= 1'b1;
      out_q   <= {1'b0, SPD_1000, 1'b1};
      evt_q   <= 1'b0;
    end else begin
      state   <= nxt_state;
      cnt     <= nxt_cnt;
      spd_q   <= nxt_spd;
      lspd_q  <= nxt_lspd;
      ldplx_q <= nxt_ldplx;
      out_q   <= {link_up, link_spd, link_dplx};
      evt_q   <= {link_up, link_spd, link_dplx}
                 != out_q;
    end
  end

  always_comb begin
    nxt_state = state;
    nxt_cnt   = cnt;
    nxt_spd   = spd_q;
    nxt_lspd  = lspd_q;
    nxt_ldplx = ldplx_q;
    unique case (state)
      S_RST: begin
        if (cnt == '0) begin
          nxt_state = S_SETTLE;
          nxt_cnt   = SET_LOAD;
        end else begin
          nxt_cnt = cnt - CNT_W'(1);
        end
      end
      S_SETTLE: begin
        if (cnt == '0) begin
          nxt_state = S_DOWN;
        end else begin
          nxt_cnt = cnt - CNT_W'(1);
        end
      end
      S_DOWN: begin
        if (db_stable && eff_ok) begin
          if (eff_gig == spd_q) begin
            nxt_state = S_UP;
            nxt_lspd  = eff;
            nxt_ldplx = db_t.dplx;
          end else begin
            nxt_state = S_RST;
            nxt_spd   = eff_gig;
            nxt_cnt   = RST_LOAD;
          end
        end
      end
      S_UP: begin
        if (db_stable) begin
          if (!eff_ok) begin
            nxt_state = S_DOWN;
          end else if (eff_gig != spd_q) begin
            nxt_state = S_RST;
            nxt_spd   = eff_gig;
            nxt_cnt   = RST_LOAD;
          end else begin
            nxt_lspd  = eff;
            nxt_ldplx = db_t.dplx;
          end
        end
      end
      default: begin
        nxt_state = S_RST;
        nxt_cnt   = RST_LOAD;
      end
    endcase
  end

  assign rx_reset   = (state == S_RST);
  assign speed      = spd_q;
  assign link_up    = (state == S_UP);
  assign link_spd   = lspd_q;
  assign link_dplx  = ldplx_q;
  assign link_event = evt_q;
  assign state_o    = state;

`ifdef RGMII_LINK_STATS_EN
  logic down_hit;
  logic respeed_hit;

  assign down_hit    = (state == S_UP) &&
                       (nxt_state == S_DOWN);
  assign respeed_hit = ((state == S_UP) ||
                        (state == S_DOWN)) &&
                       (nxt_state == S_RST);

  // clear wins over a same-cycle increment
  always_ff @(posedge clk) begin
    if (!reset_n || stat_clr) begin
      stat_down_cnt    <= '0;
      stat_respeed_cnt <= '0;
    end else begin
      if (down_hit && (stat_down_cnt != 16'hFFFF))
        stat_down_cnt <= stat_down_cnt + 16'd1;
      if (respeed_hit &&
          (stat_respeed_cnt != 16'hFFFF))
        stat_respeed_cnt <= stat_respeed_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_rgmii_link_ctrl.sv
// Directed bench for rgmii_link_ctrl with
// default parameters (1000/16/64).
module tb_rgmii_link_ctrl;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       ibs_up = 1'b0;
  logic [1:0] ibs_spd = 2'b00;
  logic       ibs_dplx = 1'b0;
  logic       cfg_force = 1'b0;
  logic [1:0] cfg_spd = 2'b00;
  logic       rx_reset;
  logic       speed;
  logic       link_up;
  logic [1:0] link_spd;
  logic       link_dplx;
  logic       link_event;
  logic [2:0] state_o;

  int total = 0;
  int bad = 0;
  int ev_cnt = 0;

  rgmii_link_ctrl dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .ibs_up    (ibs_up),
    .ibs_spd   (ibs_spd),
    .ibs_dplx  (ibs_dplx),
    .cfg_force (cfg_force),
    .cfg_spd   (cfg_spd),
    .rx_reset  (rx_reset),
    .speed     (speed),
    .link_up   (link_up),
    .link_spd  (link_spd),
    .link_dplx (link_dplx),
    .link_event(link_event),
    .state_o   (state_o)
  );

  always #5 clk = ~clk;

  always @(negedge clk)
    if (link_event === 1'b1) ev_cnt++;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    ibs_up = 1'b1;
    ibs_spd = 2'b10;
    ibs_dplx = 1'b1;
    tick(3);
    total++; if (rx_reset !== 1'b1) begin bad++; $display("FAIL rst_rx_reset got=%0b want=1", rx_reset); end
    total++; if (speed !== 1'b1) begin bad++; $display("FAIL rst_speed got=%0b want=1", speed); end
    total++; if (link_up !== 1'b0) begin bad++; $display("FAIL rst_link_up got=%0b want=0", link_up); end
    total++; if (link_spd !== 2'b10) begin bad++; $display("FAIL rst_link_spd got=%0b want=10", link_spd); end
    total++; if (link_dplx !== 1'b1) begin bad++; $display("FAIL rst_link_dplx got=%0b want=1", link_dplx); end
    total++; if (link_event !== 1'b0) begin bad++; $display("FAIL rst_event got=%0b want=0", link_event); end
    total++; if (state_o !== 3'd0) begin bad++; $display("FAIL rst_state got=%0d want=0", state_o); end
  endtask

  task automatic test_bringup();
    int n;
    ev_cnt = 0;
    reset_n = 1'b1;
    n = 0;
    while (rx_reset === 1'b1 && n < 200) begin tick(1); n++; end
    total++; if (n != 16) begin bad++; $display("FAIL up_rst_len got=%0d want=16", n); end
    total++; if (state_o !== 3'd1) begin bad++; $display("FAIL up_settle_state got=%0d want=1", state_o); end
    n = 0;
    while (state_o === 3'd1 && n < 200) begin tick(1); n++; end
    total++; if (n != 64) begin bad++; $display("FAIL up_settle_len got=%0d want=64", n); end
    total++; if (state_o !== 3'd2) begin bad++; $display("FAIL up_down_state got=%0d want=2", state_o); end
    n = 0;
    while (link_up !== 1'b1 && n < 2000) begin tick(1); n++; end
    total++; if (n != 1003) begin bad++; $display("FAIL up_latency got=%0d want=1003", n); end
    total++; if (speed !== 1'b1) begin bad++; $display("FAIL up_speed got=%0b want=1", speed); end
    total++; if (link_spd !== 2'b10) begin bad++; $display("FAIL up_link_spd got=%0b want=10", link_spd); end
    total++; if (link_event !== 1'b0) begin bad++; $display("FAIL up_evt_early got=%0b want=0", link_event); end
    tick(1);
    total++; if (link_event !== 1'b1) begin bad++; $display("FAIL up_evt_pulse got=%0b want=1", link_event); end
    tick(1);
    total++; if (link_event !== 1'b0) begin bad++; $display("FAIL up_evt_end got=%0b want=0", link_event); end
    tick(1);
    total++; if (ev_cnt != 1) begin bad++; $display("FAIL up_evt_count got=%0d want=1", ev_cnt); end
  endtask

  task automatic test_respeed();
    int n;
    ev_cnt = 0;
    ibs_spd = 2'b01;
    n = 0;
    while (link_up === 1'b1 && n < 2000) begin tick(1); n++; end
    total++; if (n != 1003) begin bad++; $display("FAIL rs_drop_lat got=%0d want=1003", n); end
    total++; if (rx_reset !== 1'b1) begin bad++; $display("FAIL rs_rx_reset got=%0b want=1", rx_reset); end
    total++; if (speed !== 1'b0) begin bad++; $display("FAIL rs_speed got=%0b want=0", speed); end
    n = 0;
    while (rx_reset === 1'b1 && n < 200) begin tick(1); n++; end
    total++; if (n != 16) begin bad++; $display("FAIL rs_rst_len got=%0d want=16", n); end
    n = 0;
    while (link_up !== 1'b1 && n < 2000) begin tick(1); n++; end
    total++; if (n != 1067) begin bad++; $display("FAIL rs_up_lat got=%0d want=1067", n); end
    total++; if (link_spd !== 2'b01) begin bad++; $display("FAIL rs_link_spd got=%0b want=01", link_spd); end
    total++; if (link_dplx !== 1'b1) begin bad++; $display("FAIL rs_link_dplx got=%0b want=1", link_dplx); end
    tick(3);
    total++; if (ev_cnt != 2) begin bad++; $display("FAIL rs_evt_count got=%0d want=2", ev_cnt); end
  endtask

  task automatic test_glitch();
    int drop;
    int hi;
    ev_cnt = 0;
    drop = 0;
    hi = 0;
    ibs_up = 1'b0;
    repeat (500) begin
      tick(1);
      if (link_up !== 1'b1) drop++;
      if (rx_reset !== 1'b0) hi++;
    end
    ibs_up = 1'b1;
    repeat (1100) begin
      tick(1);
      if (link_up !== 1'b1) drop++;
      if (rx_reset !== 1'b0) hi++;
    end
    total++; if (drop != 0) begin bad++; $display("FAIL gl_link_drop got=%0d want=0", drop); end
    total++; if (hi != 0) begin bad++; $display("FAIL gl_rx_reset got=%0d want=0", hi); end
    total++; if (ev_cnt != 0) begin bad++; $display("FAIL gl_evt_count got=%0d want=0", ev_cnt); end
    total++; if (state_o !== 3'd3) begin bad++; $display("FAIL gl_state got=%0d want=3", state_o); end
  endtask

  task automatic test_same_class();
    int hi;
    ev_cnt = 0;
    hi = 0;
    ibs_spd = 2'b00;
    ibs_dplx = 1'b0;
    repeat (1002) begin
      tick(1);
      if (rx_reset !== 1'b0) hi++;
    end
    total++; if (link_spd !== 2'b01) begin bad++; $display("FAIL sc_spd_early got=%0b want=01", link_spd); end
    tick(1);
    total++; if (link_spd !== 2'b00) begin bad++; $display("FAIL sc_link_spd got=%0b want=00", link_spd); end
    total++; if (link_dplx !== 1'b0) begin bad++; $display("FAIL sc_link_dplx got=%0b want=0", link_dplx); end
    total++; if (link_up !== 1'b1) begin bad++; $display("FAIL sc_link_up got=%0b want=1", link_up); end
    total++; if (hi != 0) begin bad++; $display("FAIL sc_rx_reset got=%0d want=0", hi); end
    tick(3);
    total++; if (ev_cnt != 1) begin bad++; $display("FAIL sc_evt_count got=%0d want=1", ev_cnt); end
  endtask

  task automatic test_force();
    int n;
    ibs_spd = 2'b10;
    ibs_dplx = 1'b1;
    n = 0;
    while (link_up === 1'b1 && n < 2000) begin tick(1); n++; end
    n = 0;
    while (link_up !== 1'b1 && n < 3000) begin tick(1); n++; end
    total++; if (speed !== 1'b1) begin bad++; $display("FAIL fo_gig_speed got=%0b want=1", speed); end
    total++; if (link_spd !== 2'b10) begin bad++; $display("FAIL fo_gig_spd got=%0b want=10", link_spd); end
    tick(3);
    ev_cnt = 0;
    cfg_spd = 2'b00;
    cfg_force = 1'b1;
    tick(1);
    total++; if (rx_reset !== 1'b1) begin bad++; $display("FAIL fo_rx_reset got=%0b want=1", rx_reset); end
    total++; if (link_up !== 1'b0) begin bad++; $display("FAIL fo_link_drop got=%0b want=0", link_up); end
    total++; if (speed !== 1'b0) begin bad++; $display("FAIL fo_speed got=%0b want=0", speed); end
    n = 0;
    while (link_up !== 1'b1 && n < 3000) begin tick(1); n++; end
    total++; if (n != 1083) begin bad++; $display("FAIL fo_up_lat got=%0d want=1083", n); end
    total++; if (link_spd !== 2'b00) begin bad++; $display("FAIL fo_link_spd got=%0b want=00", link_spd); end
    ibs_spd = 2'b11;
    tick(1010);
    total++; if (link_up !== 1'b1) begin bad++; $display("FAIL fo_rsvd_masked got=%0b want=1", link_up); end
    cfg_force = 1'b0;
    tick(1);
    total++; if (link_up !== 1'b0) begin bad++; $display("FAIL fo_rsvd_down got=%0b want=0", link_up); end
    total++; if (state_o !== 3'd2) begin bad++; $display("FAIL fo_down_state got=%0d want=2", state_o); end
    total++; if (rx_reset !== 1'b0) begin bad++; $display("FAIL fo_no_reset got=%0b want=0", rx_reset); end
    tick(3);
    total++; if (ev_cnt != 3) begin bad++; $display("FAIL fo_evt_count got=%0d want=3", ev_cnt); end
  endtask

  task automatic test_abort();
    int n;
    ev_cnt = 0;
    reset_n = 1'b0;
    tick(1);
    total++; if (link_spd !== 2'b10) begin bad++; $display("FAIL ab_rst_spd got=%0b want=10", link_spd); end
    total++; if (speed !== 1'b1) begin bad++; $display("FAIL ab_rst_speed got=%0b want=1", speed); end
    reset_n = 1'b1;
    tick(20);
    total++; if (state_o !== 3'd1) begin bad++; $display("FAIL ab_in_settle got=%0d want=1", state_o); end
    reset_n = 1'b0;
    tick(1);
    total++; if (state_o !== 3'd0) begin bad++; $display("FAIL ab_state got=%0d want=0", state_o); end
    total++; if (rx_reset !== 1'b1) begin bad++; $display("FAIL ab_rx_reset got=%0b want=1", rx_reset); end
    total++; if (link_up !== 1'b0) begin bad++; $display("FAIL ab_link_up got=%0b want=0", link_up); end
    total++; if (link_dplx !== 1'b1) begin bad++; $display("FAIL ab_link_dplx got=%0b want=1", link_dplx); end
    total++; if (link_event !== 1'b0) begin bad++; $display("FAIL ab_event got=%0b want=0", link_event); end
    reset_n = 1'b1;
    n = 0;
    while (rx_reset === 1'b1 && n < 200) begin tick(1); n++; end
    total++; if (n != 16) begin bad++; $display("FAIL ab_rst_len got=%0d want=16", n); end
    total++; if (state_o !== 3'd1) begin bad++; $display("FAIL ab_restart got=%0d want=1", state_o); end
    tick(2);
    total++; if (ev_cnt != 0) begin bad++; $display("FAIL ab_evt_count got=%0d want=0", ev_cnt); end
  endtask

  initial begin
    test_reset();
    test_bringup();
    test_respeed();
    test_glitch();
    test_same_class();
    test_force();
    test_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
